// File: rtl/nexus_nonce_scanner_if.sv
// Purpose: bundles scan control, pipeline nonce/result and host hit-queue signals of the nonce scanner.
// Latency: none (signal bundle only).
// Backpressure: host side uses found_valid/found_ready; pipeline side has none (one nonce per clock).
// Modports: slave = scanner view (drives nonce_out, found_*, status), master = host/pipeline view.
interface nexus_nonce_scanner_if #(
  parameter int NONCE_W = 64,
  parameter int HASH_W  = 64,
  parameter int CNT_W   = 16
);
  logic               start;
  logic               stop;
  logic [NONCE_W-1:0] nonce_base;
  logic [NONCE_W-1:0] nonce_limit;
  logic [HASH_W-1:0]  target;
  logic [NONCE_W-1:0] nonce_out;
  logic               nonce_valid;
  logic [HASH_W-1:0]  hash_in;
  logic               hash_valid;
  logic [NONCE_W-1:0] found_nonce;
  logic               found_valid;
  logic               found_ready;
  logic [CNT_W-1:0]   drop_count;
  logic               busy;
  logic               done;
  logic               err;

  modport slave (
    input  start, stop, nonce_base, nonce_limit, target, hash_in, hash_valid, found_ready,
    output nonce_out, nonce_valid, found_nonce, found_valid, drop_count, busy, done, err
  );

  modport master (
    output start, stop, nonce_base, nonce_limit, target, hash_in, hash_valid, found_ready,
    input  nonce_out, nonce_valid, found_nonce, found_valid, drop_count, busy, done, err
  );
endinterface

// File: rtl/nexus_nonce_scanner.sv
// Purpose: issues nonces over an inclusive (wrapping) range, pairs in-order results with nonces, queues hits.
// Latency: first nonce one clock after start; hit visible on found_* one clock after its result arrives.
// Backpressure: hit FIFO stalls on found_ready; a hit arriving while the FIFO is full (and not popped) is counted as dropped.
// Ports: clk, nHashRst (async active-low), bus (nexus_nonce_scanner_if.slave).

// Small hit queue. A push into a full queue succeeds when a pop happens in the same cycle.
module nexus_hit_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         in_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  input  logic         out_rdy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push, pop;

  always_comb begin
    out_vld  = (cnt_q != '0);
    out_dat  = mem_q[rd_ptr_q];
    in_rdy   = (cnt_q != FULL_CNT) || out_rdy;
    push     = in_vld && in_rdy;
    pop      = out_vld && out_rdy;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

module nexus_nonce_scanner #(
  parameter int NONCE_W      = 64,
  parameter int HASH_W       = 64,
  parameter int MAX_INFLIGHT = 512,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  nHashRst,
  nexus_nonce_scanner_if.slave  bus
);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic               nonce_vld_q, nonce_vld_d;
  logic [NONCE_W-1:0] limit_q, limit_d;
  logic [HASH_W-1:0]  target_q, target_d;
  logic [NONCE_W-1:0] rx_nonce_q, rx_nonce_d;
  logic [IW-1:0]      inflight_q, inflight_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic               err_q, err_d;

  logic               scanning;
  logic               accept;
  logic               hit;
  logic               fifo_in_rdy;
  logic               fifo_out_vld;
  logic [NONCE_W-1:0] fifo_out_dat;

  always_comb begin
    state_d     = state_q;
    nonce_d     = nonce_q;
    nonce_vld_d = nonce_vld_q;
    limit_d     = limit_q;
    target_d    = target_q;
    rx_nonce_d  = rx_nonce_q;
    drop_d      = drop_q;
    err_d       = err_q;

    scanning = (state_q == S_RUN) || (state_q == S_DRAIN);
    // A result only counts if something is actually outstanding; the nonce presented this
    // cycle counts as outstanding so a zero-latency pipeline is still legal.
    accept   = bus.hash_valid && scanning && ((inflight_q != '0) || nonce_vld_q);
    hit      = accept && (bus.hash_in <= target_q);

    inflight_d = inflight_q + IW'(nonce_vld_q) - IW'(accept);

    if (accept) begin
      rx_nonce_d = rx_nonce_q + NONCE_W'(1);
    end
    if (hit && !fifo_in_rdy && (drop_q != '1)) begin
      drop_d = drop_q + CNT_W'(1);
    end
    if (bus.hash_valid && !accept) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          nonce_d     = bus.nonce_base;
          nonce_vld_d = 1'b1;
          rx_nonce_d  = bus.nonce_base;
          limit_d     = bus.nonce_limit;
          target_d    = bus.target;
          drop_d      = '0;
          // A stray result in the very start cycle still flags an error.
          err_d       = bus.hash_valid;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        if ((nonce_q == limit_q) || bus.stop) begin
          nonce_vld_d = 1'b0;
          state_d     = S_DRAIN;
        end else begin
          nonce_d = nonce_q + NONCE_W'(1);
        end
      end
      S_DRAIN: begin
        if (inflight_d == '0) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nHashRst) begin
    if (!nHashRst) begin
      state_q     <= S_IDLE;
      nonce_q     <= '0;
      nonce_vld_q <= 1'b0;
      limit_q     <= '0;
      target_q    <= '0;
      rx_nonce_q  <= '0;
      inflight_q  <= '0;
      drop_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      nonce_q     <= nonce_d;
      nonce_vld_q <= nonce_vld_d;
      limit_q     <= limit_d;
      target_q    <= target_d;
      rx_nonce_q  <= rx_nonce_d;
      inflight_q  <= inflight_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
    end
  end

  // The nonce of the result being accepted is rx_nonce_q (before its increment).
  nexus_hit_fifo #(
    .W     (NONCE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_hit_fifo (
    .clk     (clk),
    .rst_n   (nHashRst),
    .in_vld  (hit),
    .in_dat  (rx_nonce_q),
    .in_rdy  (fifo_in_rdy),
    .out_vld (fifo_out_vld),
    .out_dat (fifo_out_dat),
    .out_rdy (bus.found_ready)
  );

  assign bus.nonce_out   = nonce_q;
  assign bus.nonce_valid = nonce_vld_q;
  assign bus.found_nonce = fifo_out_dat;
  assign bus.found_valid = fifo_out_vld;
  assign bus.drop_count  = drop_q;
  assign bus.busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.err         = err_q;
endmodule

// File: tb/tb_nexus_nonce_scanner.sv
// Bench for nexus_nonce_scanner: a 390-cycle pipeline stand-in returns results in issue order,
// the expected hit list is built from the hash<=target rule at issue time, and popped hits are collected.
module tb_nexus_nonce_scanner;
  localparam int LAT   = 390;
  localparam int SLOTS = 512;

  logic clk = 1'b0;
  logic nHashRst;
  always #5 clk = ~clk;

  nexus_nonce_scanner_if #(.NONCE_W(64), .HASH_W(64), .CNT_W(16)) bus ();

  nexus_nonce_scanner #(
    .NONCE_W(64), .HASH_W(64), .MAX_INFLIGHT(512), .FIFO_DEPTH(4), .CNT_W(16)
  ) dut (
    .clk      (clk),
    .nHashRst (nHashRst),
    .bus      (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic        vld;
    logic [63:0] nonce;
    logic [63:0] hash;
  } slot_t;

  slot_t       pipe [SLOTS];
  int unsigned cyc = 0;
  logic [63:0] issued[$];
  logic [63:0] exp_hits[$];
  logic [63:0] got_hits[$];
  int          hash_mode = 0;
  logic [63:0] hit_nonce = '0;
  logic [63:0] cur_target = '0;
  int          last_issue_cyc = 0;
  int          done_cyc = -1;
  logic        spur_req = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // 0: single chosen hit; 1: every result hits; 2: random mix around the target.
  function automatic logic [63:0] pick_hash(input logic [63:0] n);
    int r;
    case (hash_mode)
      0: return (n == hit_nonce) ? 64'h0 : {64{1'b1}};
      1: return 64'h0;
      default: begin
        r = $urandom_range(0, 3);
        case (r)
          0: return cur_target;
          1: return cur_target + 64'd1;
          2: return {32'h0, $urandom};
          default: return {$urandom, $urandom};
        endcase
      end
    endcase
  endfunction

  // Pipeline stand-in plus monitors, all acting on the falling edge.
  initial begin
    slot_t rd_s;
    slot_t wr_s;
    for (int i = 0; i < SLOTS; i++) pipe[i] = '0;
    bus.hash_valid = 1'b0;
    bus.hash_in    = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!nHashRst) begin
        for (int i = 0; i < SLOTS; i++) pipe[i] = '0;
        bus.hash_valid = 1'b0;
        bus.hash_in    = '0;
      end else begin
        rd_s      = pipe[(cyc + SLOTS - LAT) % SLOTS];
        wr_s.vld  = bus.nonce_valid;
        wr_s.nonce = bus.nonce_out;
        wr_s.hash = bus.nonce_valid ? pick_hash(bus.nonce_out) : 64'h0;
        if (bus.nonce_valid) begin
          issued.push_back(bus.nonce_out);
          last_issue_cyc = cyc;
          if (wr_s.hash <= cur_target) exp_hits.push_back(bus.nonce_out);
        end
        pipe[cyc % SLOTS] = wr_s;
        bus.hash_valid = rd_s.vld | spur_req;
        bus.hash_in    = rd_s.vld ? rd_s.hash : {64{1'b1}};
        if (bus.done && done_cyc < 0) done_cyc = cyc;
        if (bus.found_valid && bus.found_ready) got_hits.push_back(bus.found_nonce);
      end
    end
  end

  task automatic do_start(input logic [63:0] base, input logic [63:0] lim, input logic [63:0] tgt);
    @(posedge clk); #1;
    issued.delete();
    exp_hits.delete();
    got_hits.delete();
    cur_target      = tgt;
    bus.nonce_base  = base;
    bus.nonce_limit = lim;
    bus.target      = tgt;
    bus.start       = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    done_cyc  = -1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!bus.done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 64'(bus.done), 64'd1);
  endtask

  task automatic check_scan(input string tag, input logic [63:0] base, input int expc);
    int bad = 0;
    repeat (8) @(posedge clk);
    #1;
    check({tag, "_count"}, 64'(issued.size()), 64'(expc));
    foreach (issued[i]) if (issued[i] !== base + 64'(i)) bad++;
    check({tag, "_seq"}, 64'(bad), 64'd0);
    check({tag, "_nhits"}, 64'(got_hits.size()), 64'(exp_hits.size()));
    bad = 0;
    foreach (got_hits[i]) if (i < exp_hits.size() && got_hits[i] !== exp_hits[i]) bad++;
    check({tag, "_hits"}, 64'(bad), 64'd0);
    check({tag, "_drop"}, 64'(bus.drop_count), 64'd0);
    check({tag, "_err"}, 64'(bus.err), 64'd0);
  endtask

  initial begin
    logic [63:0] base;
    logic [63:0] first_hit;
    int len;
    int stop_at;
    int expc;
    int bad;

    bus.start = 1'b0; bus.stop = 1'b0; bus.nonce_base = '0; bus.nonce_limit = '0;
    bus.target = '0; bus.found_ready = 1'b1;
    nHashRst = 1'b1;
    #1 nHashRst = 1'b0;
    #2;
    check("rst_nonce_valid", 64'(bus.nonce_valid), 64'd0);
    check("rst_nonce_out", bus.nonce_out, 64'd0);
    check("rst_busy_done_err", {61'd0, bus.busy, bus.done, bus.err}, 64'd0);
    check("rst_found", {bus.found_nonce[62:0], bus.found_valid}, 64'd0);
    check("rst_drop", 64'(bus.drop_count), 64'd0);
    #20 nHashRst = 1'b1;

    // Stray result while idle.
    @(posedge clk); #1 spur_req = 1'b1;
    @(posedge clk); #1 spur_req = 1'b0;
    @(negedge clk);
    check("spur_err", 64'(bus.err), 64'd1);
    check("spur_no_push", 64'(bus.found_valid), 64'd0);

    // Single hit over 1001 nonces.
    hash_mode = 0;
    base      = 64'h0000_0001_FCAF_C044;
    hit_nonce = base + 64'd17;
    do_start(base, base + 64'd1000, 64'h0000_0000_FFFF_FFFF);
    check("start_clears_err", 64'(bus.err), 64'd0);
    check("start_busy", 64'(bus.busy), 64'd1);
    wait_done("single", 3000);
    // Last nonce is consumed at edge E and done rises at E+LAT; the falling-edge sightings are one further apart.
    check("single_done_latency", 64'(done_cyc - last_issue_cyc), 64'(LAT + 1));
    check_scan("single", base, 1001);
    first_hit = (got_hits.size() > 0) ? got_hits[0] : 64'hx;
    check("single_found", first_hit, 64'h0000_0001_FCAF_C055);
    check("done_held", 64'(bus.done), 64'd1);

    // Range through the wrap point with a hit on nonce 0.
    hit_nonce = 64'h0;
    base      = 64'hFFFF_FFFF_FFFF_FFFE;
    do_start(base, 64'h1, 64'h0);
    wait_done("wrap", 1000);
    check_scan("wrap", base, 4);
    first_hit = (got_hits.size() > 0) ? got_hits[0] : 64'hx;
    check("wrap_found", first_hit, 64'h0);

    // Overflow: ten hits with the host not popping.
    hash_mode       = 1;
    bus.found_ready = 1'b0;
    base            = {$urandom, $urandom};
    do_start(base, base + 64'd9, {$urandom, $urandom});
    wait_done("ovf", 1000);
    #1;
    check("ovf_count", 64'(issued.size()), 64'd10);
    check("ovf_valid", 64'(bus.found_valid), 64'd1);
    check("ovf_head", bus.found_nonce, base);
    check("ovf_drop", 64'(bus.drop_count), 64'd6);
    check("ovf_no_pop", 64'(got_hits.size()), 64'd0);
    @(posedge clk); #1 bus.found_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("ovf_npop", 64'(got_hits.size()), 64'd4);
    bad = 0;
    foreach (got_hits[i]) if (got_hits[i] !== base + 64'(i)) bad++;
    check("ovf_pop_order", 64'(bad), 64'd0);
    check("ovf_empty", 64'(bus.found_valid), 64'd0);
    check("ovf_drop_kept", 64'(bus.drop_count), 64'd6);

    // Stop on the 50th RUN cycle.
    hash_mode = 2;
    base      = {$urandom, $urandom};
    do_start(base, base + 64'd999, {32'h0, $urandom});
    repeat (49) @(posedge clk);
    #1;
    check("stop_valid_before", 64'(bus.nonce_valid), 64'd1);
    bus.stop = 1'b1;
    @(posedge clk); #1 bus.stop = 1'b0;
    check("stop_valid_after", 64'(bus.nonce_valid), 64'd0);
    check("stop_draining", 64'(bus.busy), 64'd1);
    wait_done("stop", 1000);
    check_scan("stop", base, 50);

    // Randomized scans, some near the wrap point, with a stop at a random RUN cycle.
    for (int it = 0; it < 6; it++) begin
      base = (it % 3 == 0) ? (64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 20)))
                           : {$urandom, $urandom};
      len     = $urandom_range(1, 300);
      stop_at = $urandom_range(1, 400);
      expc    = (stop_at < len) ? stop_at : len;
      do_start(base, base + 64'(len - 1), {32'h0, $urandom});
      repeat (stop_at - 1) @(posedge clk);
      #1 bus.stop = 1'b1;
      @(posedge clk); #1 bus.stop = 1'b0;
      wait_done($sformatf("rnd%0d", it), 1500);
      check_scan($sformatf("rnd%0d", it), base, expc);
    end

    // Reset during DRAIN with stale hits queued from the previous scan.
    hash_mode       = 1;
    bus.found_ready = 1'b0;
    base            = {$urandom, $urandom};
    do_start(base, base + 64'd20, 64'h0);
    wait_done("prefill", 1000);
    do_start(base, base + 64'd20, 64'h0);
    repeat (30) @(posedge clk);
    #1;
    check("pre_rst_busy", 64'(bus.busy), 64'd1);
    check("fifo_kept_on_start", 64'(bus.found_valid), 64'd1);
    #2 nHashRst = 1'b0;
    #1;
    check("arst_nonce_out", bus.nonce_out, 64'd0);
    check("arst_status", {60'd0, bus.busy, bus.done, bus.err, bus.found_valid}, 64'd0);
    check("arst_found_nonce", bus.found_nonce, 64'd0);
    check("arst_drop", 64'(bus.drop_count), 64'd0);
    @(negedge clk);
    @(posedge clk); #2 nHashRst = 1'b1;
    bus.found_ready = 1'b1;
    hash_mode = 0;
    base      = {$urandom, $urandom};
    hit_nonce = base + 64'd5;
    do_start(base, base + 64'd39, 64'd100);
    wait_done("post_rst", 1000);
    check_scan("post_rst", base, 40);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
    $fatal(1, "watchdog expired");
  end
endmodule
